// File: rtl/pipe_stage_skid_if.sv
// Valid/ready beat bus used on both sides of pipe_stage_skid.
//   valid : beat present (driven by the producer)
//   ready : consumer accepts the beat this cycle
//   data  : payload
//   ctrl  : control bits travelling with the payload
// master = producer side, slave = consumer side.
interface pipe_stage_skid_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with a two-entry skid buffer.
// Carries a payload plus control bits between two pipeline stages and keeps
// the hazard unit's STALL/FLUSH semantics. Control bits read 0 on bubbles.
// Ports:
//   CLOCK      : clock, rising edge
//   RESET      : synchronous, active-high
//   FLUSH      : discard held entries and the beat presented this cycle
//   STALL      : hold the output entry (same as OUT.ready = 0)
//   IN         : upstream beat bus (this stage is the consumer)
//   OUT        : downstream beat bus (this stage is the producer)
//   OCCUPANCY  : held entries, 0..2
//   BP_CYCLES  : saturating count of valid-but-not-accepted output cycles
module pipe_stage_skid #(
  parameter int DATA_WIDTH          = 32,
  parameter int CTRL_WIDTH          = 8,
  parameter bit ZERO_DATA_ON_BUBBLE = 1'b1,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 FLUSH,
  input  logic                 STALL,
  pipe_stage_skid_if.slave     IN,
  pipe_stage_skid_if.master    OUT,
  output logic [1:0]           OCCUPANCY,
  output logic [CNT_WIDTH-1:0] BP_CYCLES
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_WIDTH-1:0]  bp_q;

  logic in_ready;
  logic out_valid;
  logic in_fire;
  logic out_fire;
  logic backpressured;

  // Both handshake outputs come from registered state only, so neither
  // OUT.ready nor STALL reaches IN.ready combinationally.
  assign in_ready      = (state_q != FULL);
  assign out_valid     = (state_q != EMPTY);
  assign in_fire       = IN.valid & in_ready;
  assign out_fire      = out_valid & OUT.ready & ~STALL;
  assign backpressured = out_valid & ~(OUT.ready & ~STALL);

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (FLUSH) begin
      // The beat presented this cycle is dropped even though IN.ready=1.
      state_d     = EMPTY;
      out_data_d  = '0;
      out_ctrl_d  = '0;
      skid_data_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            out_data_d = IN.data;
            out_ctrl_d = IN.ctrl;
            state_d    = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            out_data_d = IN.data;
            out_ctrl_d = IN.ctrl;
          end else if (in_fire) begin
            // Output entry is held; the new beat parks behind it.
            skid_data_d = IN.data;
            skid_ctrl_d = IN.ctrl;
            state_d     = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            out_data_d = skid_data_q;
            out_ctrl_d = skid_ctrl_q;
            state_d    = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      out_ctrl_q  <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_ctrl_q  <= out_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  // Counts in flush cycles too; only RESET clears it.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      bp_q <= '0;
    end else if (backpressured && (bp_q != '1)) begin
      bp_q <= bp_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    OCCUPANCY = 2'd0;
    unique case (state_q)
      EMPTY:   OCCUPANCY = 2'd0;
      ONE:     OCCUPANCY = 2'd1;
      FULL:    OCCUPANCY = 2'd2;
      default: OCCUPANCY = 2'd0;
    endcase
  end

  assign IN.ready  = in_ready;
  assign OUT.valid = out_valid;
  assign OUT.ctrl  = out_valid ? out_ctrl_q : '0;
  assign OUT.data  = (ZERO_DATA_ON_BUBBLE && !out_valid) ? '0 : out_data_q;
  assign BP_CYCLES = bp_q;

endmodule
